// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage, producer side of the IF->ID
//               interface. Owns the PC, fetches one word at a time over an
//               SRAM-like instruction bus (addr_ok/data_ok handshake, at most
//               one outstanding request) and holds {inst,pc} for ID until
//               ds_allowin. The branch bus from ID is consumed only at the
//               handoff of the delay-slot instruction.
// Parameters  : RESET_PC - address of the first fetch after reset
// Ports       : clk, reset (sync, active-high)
//               ds_allowin, br_bus[32:0]               - from ID
//               fs_to_ds_valid, fs_to_ds_bus[63:0],
//               fs_adef                                - to ID
//               inst_req/wr/size/addr/wdata            - to inst bus
//               inst_addr_ok/data_ok/rdata             - from inst bus
// Config      : IF_ADEF_CHK_EN - when defined, a misaligned PC is not issued
//               on the bus; a nop is handed to ID with fs_adef set.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        fs_adef,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        adef_buf_q, adef_buf_d;
    logic        misaligned;

`ifdef IF_ADEF_CHK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            inst_buf_q <= 32'h0;
            adef_buf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
            adef_buf_q <= adef_buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_buf_d = inst_buf_q;
        adef_buf_d = adef_buf_q;
        case (state_q)
            S_REQ: begin
                if (misaligned) begin
                    // Skip the bus entirely and hand a nop to ID so the
                    // exception is raised in program order.
                    state_d    = S_HOLD;
                    inst_buf_d = 32'h0;
                    adef_buf_d = 1'b1;
                end else if (inst_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    inst_buf_d = inst_rdata;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ds_allowin) begin
                    // The instruction leaving now is the delay slot, so any
                    // branch in ID is resolved on br_bus this same cycle.
                    pc_d       = br_bus[32] ? br_bus[31:0] : pc_q + 32'd4;
                    adef_buf_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign inst_req       = (state_q == S_REQ) && !misaligned;
    assign inst_wr        = 1'b0;
    assign inst_size      = 2'b10;
    assign inst_addr      = pc_q;
    assign inst_wdata     = 32'h0;

    assign fs_to_ds_valid = (state_q == S_HOLD);
    // Low half always carries the PC: ID builds branch targets from it.
    assign fs_to_ds_bus   = {inst_buf_q, pc_q};

`ifdef IF_ADEF_CHK_EN
    assign fs_adef        = (state_q == S_HOLD) && adef_buf_q;
`else
    assign fs_adef        = 1'b0;
`endif

endmodule
`default_nettype wire
